packet_stream_decoder: RTL and testbench
========================================

// Module: packet_stream_decoder
// PURPOSE
//  Parametrised successor packet decoder. Consumes whole words from the UART word assembler and frames packets as SOP, CMD, LEN, payload.
//  Streams payload words to the payload FIFO and flags packet completion, resync and errors to downstream control.
//  Adds zero-length support, a length limit, FIFO-overflow detection, an inactivity timeout and error reporting.
// PARAMETERS
//  WORD_W       32            word width; multiple of 8, >= 16
//  CMD_W        2             command field width; taken from word MSBs [WORD_W-1 -: CMD_W]
//  LEN_W        16            payload length field width (words); LEN_W <= WORD_W
//  MAX_WORDS    4096          largest accepted payload length; must be <= 2**LEN_W-1
//  LEN_BYTESWAP 1             1: byte-reverse the LEN word before use (little-endian host)
//  RESYNC_WORD  32'h1EDC6F41  resync magic word
//  SOP_WORD     32'h741B8CD7  start-of-packet magic word
//  TIMEOUT_CYC  1000000       idle cycles allowed between words mid-packet; 0 disables; timer width $clog2(TIMEOUT_CYC+1)
// PORTS
//  i_clk            in   1        clock
//  i_reset          in   1        asynchronous, active-high reset
//  i_word_valid     in   1        1-cycle strobe; i_word_data valid
//  i_word_data      in   WORD_W   received word
//  i_payload_full   in   1        payload FIFO cannot accept a write this cycle
//  o_payload_valid  out  1        FIFO write strobe
//  o_payload_data   out  WORD_W   payload word
//  o_payload_last   out  1        qualifies o_payload_valid; final word of packet
//  o_cmd            out  CMD_W    command of current/last packet; held until next CMD word
//  o_len            out  LEN_W    decoded payload length; held until next LEN word
//  o_pkt_start      out  1        pulse: CMD and LEN accepted, payload begins
//  o_pkt_done       out  1        pulse: packet complete, including LEN=0
//  o_pkt_error      out  1        pulse: packet aborted
//  o_err_code       out  2        cause, valid with o_pkt_error; held until next error
//  o_resync         out  1        pulse: RESYNC word received; downstream soft reset
// BEHAVIOUR
//  - All outputs are registered. Every response appears the cycle after the i_word_valid or timer event that causes it.
//  - Reset values: state IDLE; all pulses, valid and last = 0; o_cmd, o_len, o_payload_data, o_err_code = 0; counters = 0.
//  - A RESYNC word has priority in every state, including PAYLOAD: o_resync=1, go to IDLE, no error, not forwarded as data.
//  - IDLE: non-SOP words are discarded silently. SOP -> CMD.
//  - CMD: next word -> o_cmd = word[WORD_W-1 -: CMD_W]. Go to LEN.
//  - LEN: word optionally byte-reversed; L = low LEN_W bits.
//      L > MAX_WORDS -> o_pkt_error, ERR_LEN=2'd1, go to IDLE.
//      L = 0 -> o_pkt_start and o_pkt_done in the same cycle, go to IDLE.
//      else -> o_len=L, o_pkt_start, count=0, go to PAYLOAD.
//  - PAYLOAD: each word with !i_payload_full -> o_payload_valid=1, data forwarded, count++.
//      On count+1==L: o_payload_last=1 and o_pkt_done=1 in the same cycle, go to IDLE.
//  - Overflow: word arrives with i_payload_full=1 -> word dropped, o_pkt_error, ERR_OVF=2'd2, go to IDLE.
//      The remaining payload is ignored as IDLE noise.
//  - Timeout (TIMEOUT_CYC>0): timer clears on every i_word_valid and in IDLE; counts in CMD, LEN and PAYLOAD.
//      Reaching TIMEOUT_CYC -> o_pkt_error, ERR_TIMEOUT=2'd3, go to IDLE.
//      A word arriving in the expiry cycle wins: timer clears, no error.
//  - An SOP word seen in CMD, LEN or PAYLOAD is treated as ordinary data; only RESYNC breaks framing.
//  - Async reset mid-packet: immediate return to reset values. A partial packet produces no done and no error.
//  - Payload counter width LEN_W. L <= MAX_WORDS, so the counter never wraps.
// STRUCTURE
//  - Package packet_decode_pkg: state encoding (IDLE, CMD, LEN, PAYLOAD), ERR_* codes, default RESYNC/SOP constants.
//  - Sub-module pkt_timeout_timer (clear, enable, expired pulse; parameter TIMEOUT_CYC) is natural.
//  - Byteswap is a generate loop in the top level.
// TESTING
//  1. SOP, CMD=32'hC000_0000, LEN=32'h0300_0000, payload A,B,C
//     -> o_cmd=2'b11, o_len=3, three valid writes, last and done on C only.
//  2. SOP, CMD, LEN=0 -> o_pkt_start and o_pkt_done on the same cycle, no o_payload_valid.
//  3. SOP, CMD, LEN=32'h0110_0000 (4097 > MAX_WORDS) -> o_pkt_error, err_code=1, then IDLE.
//  4. LEN=4 packet; assert i_payload_full during the 2nd word -> one write, o_pkt_error err_code=2.
//     Words 3 and 4 are ignored; the next SOP packet decodes cleanly.
//  5. TIMEOUT_CYC=16; SOP, CMD, then 16 idle cycles -> o_pkt_error err_code=3.
//     Repeat with a word at idle cycle 16 -> no error.
//  6. RESYNC mid-payload -> o_resync pulse, no write, no done.
//     Also: i_reset mid-packet -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/packet_decode_pkg.sv
// Shared encodings for the packet stream decoder: FSM states, error causes and the
// default framing magic words.
package packet_decode_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CMD     = 2'd1;
  localparam logic [1:0] ST_LEN     = 2'd2;
  localparam logic [1:0] ST_PAYLOAD = 2'd3;

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_OVF     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [31:0] RESYNC_WORD_DEF = 32'h1EDC6F41;
  localparam logic [31:0] SOP_WORD_DEF    = 32'h741B8CD7;

endpackage

// File: rtl/pkt_timeout_timer.sv
// Inactivity timer: counts enabled cycles since the last clear and pulses o_expired
// combinationally in the cycle the count reaches TIMEOUT_CYC. TIMEOUT_CYC=0 disables it.
module pkt_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{i_clk, i_reset, i_clear, i_enable};
      assign o_expired     = 1'b0;
    end else begin : g_on
      localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);
      logic [TW-1:0] count_q;

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          count_q <= '0;
        end else if (i_clear) begin
          count_q <= '0;
        end else if (i_enable) begin
          count_q <= count_q + TW'(1);
        end
      end

      // A clear in the expiry cycle (word arrival) suppresses the pulse.
      assign o_expired = i_enable && !i_clear && (count_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/packet_stream_decoder.sv
// Frames assembled words into SOP/CMD/LEN/payload packets, streams payload to the FIFO
// and reports packet start/done, errors and resync. All outputs are registered.
module packet_stream_decoder
  import packet_decode_pkg::*;
#(
  parameter int unsigned     WORD_W       = 32,
  parameter int unsigned     CMD_W        = 2,
  parameter int unsigned     LEN_W        = 16,
  parameter int unsigned     MAX_WORDS    = 4096,
  parameter bit              LEN_BYTESWAP = 1'b1,
  parameter logic [WORD_W-1:0] RESYNC_WORD = WORD_W'(RESYNC_WORD_DEF),
  parameter logic [WORD_W-1:0] SOP_WORD    = WORD_W'(SOP_WORD_DEF),
  parameter int unsigned     TIMEOUT_CYC  = 1000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_word_valid,
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_payload_full,
  output logic              o_payload_valid,
  output logic [WORD_W-1:0] o_payload_data,
  output logic              o_payload_last,
  output logic [CMD_W-1:0]  o_cmd,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_pkt_start,
  output logic              o_pkt_done,
  output logic              o_pkt_error,
  output logic [1:0]        o_err_code,
  output logic              o_resync
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_WORDS);

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  count_q, count_d, count_inc;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              valid_q, valid_d, last_q, last_d;
  logic              start_q, start_d, done_q, done_d;
  logic              error_q, error_d, resync_q, resync_d;
  logic              tmr_expired;

  // LEN word arrives little-endian from the host; reverse byte order before use.
  logic [WORD_W-1:0] len_swapped, len_word;
  logic [LEN_W-1:0]  len_val;

  generate
    for (genvar b = 0; b < WORD_W / 8; b++) begin : g_swap
      assign len_swapped[8*b +: 8] = i_word_data[WORD_W-8-8*b +: 8];
    end
    if (LEN_W < WORD_W) begin : g_len_hi
      logic unused_len_hi;
      assign unused_len_hi = ^len_word[WORD_W-1:LEN_W];
    end
  endgenerate

  assign len_word  = LEN_BYTESWAP ? len_swapped : i_word_data;
  assign len_val   = len_word[LEN_W-1:0];
  assign count_inc = count_q + LEN_W'(1);

  pkt_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (i_word_valid || (state_q == ST_IDLE)),
    .i_enable  (state_q != ST_IDLE),
    .o_expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    data_d     = data_q;
    err_code_d = err_code_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    resync_d   = 1'b0;

    if (i_word_valid) begin
      if (i_word_data == RESYNC_WORD) begin
        resync_d = 1'b1;
        state_d  = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (i_word_data == SOP_WORD) state_d = ST_CMD;
          end
          ST_CMD: begin
            cmd_d   = i_word_data[WORD_W-1 -: CMD_W];
            state_d = ST_LEN;
          end
          ST_LEN: begin
            len_d = len_val;
            if (len_val > MAX_L) begin
              error_d    = 1'b1;
              err_code_d = ERR_LEN;
              state_d    = ST_IDLE;
            end else if (len_val == '0) begin
              start_d = 1'b1;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              start_d = 1'b1;
              count_d = '0;
              state_d = ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (i_payload_full) begin
              error_d    = 1'b1;
              err_code_d = ERR_OVF;
              state_d    = ST_IDLE;
            end else begin
              valid_d = 1'b1;
              data_d  = i_word_data;
              count_d = count_inc;
              if (count_inc == len_q) begin
                last_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end
        endcase
      end
    end else if (tmr_expired) begin
      error_d    = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      data_q     <= '0;
      err_code_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      data_q     <= data_d;
      err_code_q <= err_code_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      start_q    <= start_d;
      done_q     <= done_d;
      error_q    <= error_d;
      resync_q   <= resync_d;
    end
  end

  assign o_payload_valid = valid_q;
  assign o_payload_data  = data_q;
  assign o_payload_last  = last_q;
  assign o_cmd           = cmd_q;
  assign o_len           = len_q;
  assign o_pkt_start     = start_q;
  assign o_pkt_done      = done_q;
  assign o_pkt_error     = error_q;
  assign o_err_code      = err_code_q;
  assign o_resync        = resync_q;

endmodule

// File: tb/tb_packet_stream_decoder.sv
// Directed bench for packet_stream_decoder with a 16-cycle inactivity timeout.
module tb_packet_stream_decoder;

  localparam logic [31:0] SOP    = 32'h741B8CD7;
  localparam logic [31:0] RESYNC = 32'h1EDC6F41;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_word_valid;
  logic [31:0] i_word_data;
  logic        i_payload_full;
  logic        o_payload_valid;
  logic [31:0] o_payload_data;
  logic        o_payload_last;
  logic [1:0]  o_cmd;
  logic [15:0] o_len;
  logic        o_pkt_start;
  logic        o_pkt_done;
  logic        o_pkt_error;
  logic [1:0]  o_err_code;
  logic        o_resync;

  int checks = 0;
  int errors = 0;

  packet_stream_decoder #(
    .WORD_W       (32),
    .CMD_W        (2),
    .LEN_W        (16),
    .MAX_WORDS    (4096),
    .LEN_BYTESWAP (1'b1),
    .RESYNC_WORD  (RESYNC),
    .SOP_WORD     (SOP),
    .TIMEOUT_CYC  (16)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_word_valid    (i_word_valid),
    .i_word_data     (i_word_data),
    .i_payload_full  (i_payload_full),
    .o_payload_valid (o_payload_valid),
    .o_payload_data  (o_payload_data),
    .o_payload_last  (o_payload_last),
    .o_cmd           (o_cmd),
    .o_len           (o_len),
    .o_pkt_start     (o_pkt_start),
    .o_pkt_done      (o_pkt_done),
    .o_pkt_error     (o_pkt_error),
    .o_err_code      (o_err_code),
    .o_resync        (o_resync)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present one word for one cycle; returns 1 time unit after the sampling edge.
  task automatic send(input logic [31:0] d, input logic full);
    @(negedge i_clk);
    i_word_valid   = 1'b1;
    i_word_data    = d;
    i_payload_full = full;
    @(posedge i_clk);
    #1;
    i_word_valid   = 1'b0;
    i_payload_full = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    i_reset        = 1'b1;
    i_word_valid   = 1'b0;
    i_word_data    = '0;
    i_payload_full = 1'b0;
    idle(2);
    chk("rst_valid", 32'(o_payload_valid), 32'd0);
    chk("rst_cmd", 32'(o_cmd), 32'd0);
    chk("rst_len", 32'(o_len), 32'd0);
    chk("rst_err_code", 32'(o_err_code), 32'd0);
    chk("rst_pulses", {27'd0, o_pkt_start, o_pkt_done, o_pkt_error, o_resync, o_payload_last},
        32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // 1: three-word packet
    send(SOP, 1'b0);
    send(32'hC000_0000, 1'b0);
    chk("t1_cmd", 32'(o_cmd), 32'd3);
    send(32'h0300_0000, 1'b0);
    chk("t1_start", 32'(o_pkt_start), 32'd1);
    chk("t1_len", 32'(o_len), 32'd3);
    send(32'hAAAA_0001, 1'b0);
    chk("t1_a_valid", 32'(o_payload_valid), 32'd1);
    chk("t1_a_data", o_payload_data, 32'hAAAA_0001);
    chk("t1_a_last_done", {30'd0, o_payload_last, o_pkt_done}, 32'd0);
    send(32'hBBBB_0002, 1'b0);
    chk("t1_b_valid", 32'(o_payload_valid), 32'd1);
    chk("t1_b_last", 32'(o_payload_last), 32'd0);
    send(32'hCCCC_0003, 1'b0);
    chk("t1_c_data", o_payload_data, 32'hCCCC_0003);
    chk("t1_c_last_done", {30'd0, o_payload_last, o_pkt_done}, 32'd3);
    idle(1);
    chk("t1_after", {29'd0, o_payload_valid, o_payload_last, o_pkt_done}, 32'd0);

    // 2: zero-length packet
    send(SOP, 1'b0);
    send(32'h4000_0000, 1'b0);
    send(32'h0000_0000, 1'b0);
    chk("t2_start_done", {30'd0, o_pkt_start, o_pkt_done}, 32'd3);
    chk("t2_no_write", 32'(o_payload_valid), 32'd0);
    chk("t2_cmd", 32'(o_cmd), 32'd1);
    send(32'h1234_5678, 1'b0);
    chk("t2_idle_noise", {30'd0, o_payload_valid, o_pkt_start}, 32'd0);

    // 3: length above the limit
    send(SOP, 1'b0);
    send(32'h8000_0000, 1'b0);
    send(32'h0110_0000, 1'b0);
    chk("t3_error", 32'(o_pkt_error), 32'd1);
    chk("t3_err_code", 32'(o_err_code), 32'd1);
    chk("t3_no_start", 32'(o_pkt_start), 32'd0);
    send(32'h0100_0000, 1'b0);
    chk("t3_idle", {30'd0, o_payload_valid, o_pkt_start}, 32'd0);

    // 4: FIFO overflow on second payload word
    send(SOP, 1'b0);
    send(32'h4000_0000, 1'b0);
    send(32'h0400_0000, 1'b0);
    chk("t4_len", 32'(o_len), 32'd4);
    send(32'h0000_00D1, 1'b0);
    chk("t4_w1_valid", 32'(o_payload_valid), 32'd1);
    send(32'h0000_00D2, 1'b1);
    chk("t4_w2_dropped", 32'(o_payload_valid), 32'd0);
    chk("t4_error", 32'(o_pkt_error), 32'd1);
    chk("t4_err_code", 32'(o_err_code), 32'd2);
    send(32'h0000_00D3, 1'b0);
    chk("t4_w3_ignored", {30'd0, o_payload_valid, o_pkt_done}, 32'd0);
    send(32'h0000_00D4, 1'b0);
    chk("t4_w4_ignored", {30'd0, o_payload_valid, o_pkt_done}, 32'd0);
    send(SOP, 1'b0);
    send(32'h0000_0000, 1'b0);
    chk("t4_next_cmd", 32'(o_cmd), 32'd0);
    send(32'h0100_0000, 1'b0);
    chk("t4_next_start", 32'(o_pkt_start), 32'd1);
    send(32'h0000_00E1, 1'b0);
    chk("t4_next_word", {29'd0, o_payload_valid, o_payload_last, o_pkt_done}, 32'd7);
    chk("t4_next_data", o_payload_data, 32'h0000_00E1);
    chk("t4_next_no_err", 32'(o_pkt_error), 32'd0);

    // 5a: timeout after 16 idle cycles in LEN
    send(SOP, 1'b0);
    send(32'hC000_0000, 1'b0);
    idle(15);
    chk("t5_no_err_15", 32'(o_pkt_error), 32'd0);
    idle(1);
    chk("t5_timeout", 32'(o_pkt_error), 32'd1);
    chk("t5_err_code", 32'(o_err_code), 32'd3);
    idle(1);
    chk("t5_pulse_once", 32'(o_pkt_error), 32'd0);

    // 5b: word lands in the expiry cycle and wins
    send(SOP, 1'b0);
    send(32'h8000_0000, 1'b0);
    idle(15);
    send(32'h0000_0000, 1'b0);
    chk("t5b_no_err", 32'(o_pkt_error), 32'd0);
    chk("t5b_len_taken", {30'd0, o_pkt_start, o_pkt_done}, 32'd3);

    // 6: resync mid-payload
    send(SOP, 1'b0);
    send(32'h4000_0000, 1'b0);
    send(32'h0200_0000, 1'b0);
    send(32'h0000_00F1, 1'b0);
    chk("t6_w1_valid", 32'(o_payload_valid), 32'd1);
    send(RESYNC, 1'b0);
    chk("t6_resync", 32'(o_resync), 32'd1);
    chk("t6_quiet", {29'd0, o_payload_valid, o_pkt_done, o_pkt_error}, 32'd0);
    send(32'h0000_00F2, 1'b0);
    chk("t6_idle_after", {30'd0, o_payload_valid, o_pkt_done}, 32'd0);

    // 6b: asynchronous reset mid-packet
    send(SOP, 1'b0);
    send(32'h8000_0000, 1'b0);
    send(32'h0300_0000, 1'b0);
    send(32'h0000_0A01, 1'b0);
    chk("t6b_pre_valid", 32'(o_payload_valid), 32'd1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("t6b_rst_valid", 32'(o_payload_valid), 32'd0);
    chk("t6b_rst_data", o_payload_data, 32'd0);
    chk("t6b_rst_cmd", 32'(o_cmd), 32'd0);
    chk("t6b_rst_len", 32'(o_len), 32'd0);
    chk("t6b_rst_err_code", 32'(o_err_code), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    send(32'h0000_0A02, 1'b0);
    send(32'h0000_0A03, 1'b0);
    chk("t6b_no_done_err", {29'd0, o_payload_valid, o_pkt_done, o_pkt_error}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
